// File: rtl/io_bridge_pkg.sv
// Shared sizing helpers and FIFO entry layout for the core IO bridge.
package io_bridge_pkg;

    localparam int ENTRY_DATA_LSB = 0;

    // Address width never collapses to zero bits, even for a single channel.
    function automatic int addr_width(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

    function automatic int entry_addr_lsb(input int nubits);
        return nubits;
    endfunction

    function automatic int entry_width(input int nubits, input int aw);
        return nubits + aw;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full queue is dropped
// unless a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [LOG2_DEPTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == (LOG2_DEPTH+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign rdata    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + LOG2_DEPTH'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (LOG2_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG2_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_port_bridge.sv
// Bridges the core's IO pins to per-channel input holding registers and an
// output write queue, with interrupt and sticky status generation.
module io_port_bridge
    import io_bridge_pkg::*;
#(
    parameter int                NUBITS = 32,
    parameter int                NUIOIN = 8,
    parameter int                NUIOOU = 8,
    parameter int                FDEPTH = 2,
    parameter logic [NUIOIN-1:0] ITRMSK = '0,
    localparam int               AW_I   = addr_width(NUIOIN),
    localparam int               AW_O   = addr_width(NUIOOU)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    input  logic [AW_I-1:0]          addr_in,
    output logic [NUBITS-1:0]        io_in,
    input  logic                     out_en,
    input  logic [AW_O-1:0]          addr_out,
    input  logic [NUBITS-1:0]        data_out,
    output logic                     itr,
    input  logic [NUIOIN*NUBITS-1:0] ext_in_data,
    input  logic [NUIOIN-1:0]        ext_in_valid,
    output logic [NUIOIN-1:0]        ext_in_ready,
    output logic [AW_O-1:0]          ext_out_addr,
    output logic [NUBITS-1:0]        ext_out_data,
    output logic                     ext_out_valid,
    input  logic                     ext_out_ready,
    input  logic                     stat_clr,
    output logic                     stat_ovf,
    output logic                     stat_udf
);

    localparam int EW = entry_width(NUBITS, AW_O);
    localparam int AL = entry_addr_lsb(NUBITS);

    logic [NUBITS-1:0] hold_q [NUIOIN];
    logic [NUIOIN-1:0] full_q;
    logic [NUIOIN-1:0] pop;
    logic [NUIOIN-1:0] load;
    logic              arr;
    logic              udf_set;

    // Ready looks through a same-cycle pop so a channel can be refilled back to back.
    for (genvar i = 0; i < NUIOIN; i++) begin : g_ch
        logic [NUBITS-1:0] hold_r;
        logic              full_r;

        assign pop[i]          = req_in && (addr_in == AW_I'(i));
        assign ext_in_ready[i] = ~full_r | pop[i];
        assign load[i]         = ext_in_valid[i] & ext_in_ready[i];
        assign hold_q[i]       = hold_r;
        assign full_q[i]       = full_r;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hold_r <= '0;
                full_r <= 1'b0;
            end else if (load[i]) begin
                hold_r <= ext_in_data[i*NUBITS +: NUBITS];
                full_r <= 1'b1;
            end else if (pop[i]) begin
                full_r <= 1'b0;
            end
        end
    end

    // Out-of-range channel selects read as zero and match no pop bit.
    always_comb begin
        io_in = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (addr_in == AW_I'(k)) io_in = hold_q[k];
        end
    end

    assign udf_set = |(pop & ~full_q);
    assign arr     = |(ITRMSK & ~full_q & load);

    logic [EW-1:0]     wentry;
    logic [EW-1:0]     hentry;
    logic [FDEPTH:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_ovf;
    logic              fifo_pop;
    logic              fifo_unused;

    assign wentry        = {addr_out, data_out};
    assign ext_out_valid = (fifo_count != '0);
    assign fifo_pop      = ext_out_valid && ext_out_ready;
    assign ext_out_data  = hentry[ENTRY_DATA_LSB +: NUBITS];
    assign ext_out_addr  = hentry[AL +: AW_O];
    assign fifo_unused   = &{1'b0, fifo_full, fifo_empty};

    sync_fifo #(
        .WIDTH      (EW),
        .LOG2_DEPTH (FDEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (out_en),
        .pop      (fifo_pop),
        .wdata    (wentry),
        .rdata    (hentry),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    // A clear in the same cycle as a new event wins over the set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            itr      <= 1'b0;
            stat_ovf <= 1'b0;
            stat_udf <= 1'b0;
        end else begin
            itr <= arr;
            if (stat_clr) begin
                stat_ovf <= 1'b0;
                stat_udf <= 1'b0;
            end else begin
                if (fifo_ovf) stat_ovf <= 1'b1;
                if (udf_set)  stat_udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed-vector bench for io_port_bridge: a default-sized instance plus a
// narrow instance whose channel counts leave out-of-range addresses reachable.
module tb_io_port_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_in;
    logic [2:0]    addr_in;
    logic [31:0]   io_in;
    logic          out_en;
    logic [2:0]    addr_out;
    logic [31:0]   data_out;
    logic          itr;
    logic [255:0]  ext_in_data;
    logic [7:0]    ext_in_valid;
    logic [7:0]    ext_in_ready;
    logic [2:0]    ext_out_addr;
    logic [31:0]   ext_out_data;
    logic          ext_out_valid;
    logic          ext_out_ready;
    logic          stat_clr;
    logic          stat_ovf;
    logic          stat_udf;

    logic          s_req;
    logic [2:0]    s_addr_in;
    logic [31:0]   s_io_in;
    logic          s_out_en;
    logic [2:0]    s_addr_out;
    logic [31:0]   s_data_out;
    logic          s_itr;
    logic [191:0]  s_ext_in_data;
    logic [5:0]    s_ext_in_valid;
    logic [5:0]    s_ext_in_ready;
    logic [2:0]    s_ext_out_addr;
    logic [31:0]   s_ext_out_data;
    logic          s_ext_out_valid;
    logic          s_ext_out_ready;
    logic          s_stat_clr;
    logic          s_stat_ovf;
    logic          s_stat_udf;

    int n_compared   = 0;
    int n_mismatched = 0;

    io_port_bridge #(
        .NUBITS (32), .NUIOIN (8), .NUIOOU (8), .FDEPTH (2), .ITRMSK (8'h04)
    ) dut (
        .clk (clk), .rst (rst), .req_in (req_in), .addr_in (addr_in), .io_in (io_in),
        .out_en (out_en), .addr_out (addr_out), .data_out (data_out), .itr (itr),
        .ext_in_data (ext_in_data), .ext_in_valid (ext_in_valid), .ext_in_ready (ext_in_ready),
        .ext_out_addr (ext_out_addr), .ext_out_data (ext_out_data), .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready), .stat_clr (stat_clr), .stat_ovf (stat_ovf), .stat_udf (stat_udf)
    );

    io_port_bridge #(
        .NUBITS (32), .NUIOIN (6), .NUIOOU (5), .FDEPTH (2), .ITRMSK (6'h20)
    ) dut_small (
        .clk (clk), .rst (rst), .req_in (s_req), .addr_in (s_addr_in), .io_in (s_io_in),
        .out_en (s_out_en), .addr_out (s_addr_out), .data_out (s_data_out), .itr (s_itr),
        .ext_in_data (s_ext_in_data), .ext_in_valid (s_ext_in_valid), .ext_in_ready (s_ext_in_ready),
        .ext_out_addr (s_ext_out_addr), .ext_out_data (s_ext_out_data), .ext_out_valid (s_ext_out_valid),
        .ext_out_ready (s_ext_out_ready), .stat_clr (s_stat_clr), .stat_ovf (s_stat_ovf), .stat_udf (s_stat_udf)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [2:0] ai, input logic oe,
                                 input logic [2:0] ao, input logic [31:0] dout,
                                 input logic rdy, input logic clr);
        req_in        = r;
        addr_in       = ai;
        out_en        = oe;
        addr_out      = ao;
        data_out      = dout;
        ext_out_ready = rdy;
        stat_clr      = clr;
        #1;
    endtask

    task automatic loadChannel(input int ch, input logic [31:0] d);
        ext_in_data[ch*32 +: 32] = d;
        ext_in_valid             = 8'(1) << ch;
    endtask

    initial begin
        rst = 1'b0;
        req_in = 0; addr_in = 0; out_en = 0; addr_out = 0; data_out = 0;
        ext_in_data = '0; ext_in_valid = '0; ext_out_ready = 0; stat_clr = 0;
        s_req = 0; s_addr_in = 0; s_out_en = 0; s_addr_out = 0; s_data_out = 0;
        s_ext_in_data = '0; s_ext_in_valid = '0; s_ext_out_ready = 0; s_stat_clr = 0;
        #2;
        checkOutput("rst_io_in", io_in, 0);
        checkOutput("rst_valid", ext_out_valid, 0);
        checkOutput("rst_ready", ext_in_ready, 8'hff);
        checkOutput("rst_itr", itr, 0);
        checkOutput("rst_ovf", stat_ovf, 0);
        checkOutput("rst_udf", stat_udf, 0);

        // Reset mid-fill: three queued entries and a held channel are discarded.
        @(posedge clk); #1;
        rst = 1'b1;
        loadChannel(3, 32'hdead);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 0, 1, 3'(k), 32'(k*10), 0, 0);
            clockEdge();
            ext_in_valid = '0;
        end
        applyStimulus(0, 3, 0, 0, 0, 0, 0);
        checkOutput("fill_valid", ext_out_valid, 1);
        checkOutput("fill_head_addr", ext_out_addr, 1);
        checkOutput("fill_head_data", ext_out_data, 10);
        checkOutput("fill_ch3_held", io_in, 32'hdead);
        rst = 1'b0;
        #1;
        checkOutput("midrst_valid", ext_out_valid, 0);
        checkOutput("midrst_io_in", io_in, 0);
        checkOutput("midrst_ready", ext_in_ready, 8'hff);
        clockEdge();
        clockEdge();
        checkOutput("rstlow_valid", ext_out_valid, 0);
        checkOutput("rstlow_itr", itr, 0);
        rst = 1'b1;
        clockEdge();
        checkOutput("rel_valid", ext_out_valid, 0);
        checkOutput("rel_io_in", io_in, 0);
        checkOutput("rel_ready", ext_in_ready, 8'hff);
        checkOutput("rel_itr", itr, 0);

        // Masked channel 2 load and read.
        loadChannel(2, 32'h0000_1234);
        applyStimulus(0, 2, 0, 0, 0, 0, 0);
        checkOutput("ld2_ready", ext_in_ready[2], 1);
        checkOutput("ld2_itr_before", itr, 0);
        clockEdge();
        ext_in_valid = '0;
        #1;
        checkOutput("ld2_itr_pulse", itr, 1);
        checkOutput("ld2_full_ready", ext_in_ready[2], 0);
        checkOutput("ld2_io_in", io_in, 32'h1234);
        clockEdge();
        checkOutput("ld2_itr_drop", itr, 0);
        applyStimulus(1, 2, 0, 0, 0, 0, 0);
        checkOutput("rd2_io_in", io_in, 32'h1234);
        checkOutput("rd2_ready_pop", ext_in_ready[2], 1);
        clockEdge();
        applyStimulus(0, 2, 0, 0, 0, 0, 0);
        checkOutput("rd2_ready_after", ext_in_ready[2], 1);
        checkOutput("rd2_udf", stat_udf, 0);

        // Back-to-back pop and reload on channel 2.
        loadChannel(2, 32'd5);
        clockEdge();
        ext_in_valid = '0;
        clockEdge();
        checkOutput("b2b_itr_idle", itr, 0);
        loadChannel(2, 32'd7);
        applyStimulus(1, 2, 0, 0, 0, 0, 0);
        checkOutput("b2b_old_value", io_in, 5);
        checkOutput("b2b_ready", ext_in_ready[2], 1);
        clockEdge();
        ext_in_valid = '0;
        applyStimulus(0, 2, 0, 0, 0, 0, 0);
        checkOutput("b2b_no_itr", itr, 0);
        checkOutput("b2b_still_full", ext_in_ready[2], 0);
        applyStimulus(1, 2, 0, 0, 0, 0, 0);
        checkOutput("b2b_new_value", io_in, 7);
        clockEdge();
        applyStimulus(0, 2, 0, 0, 0, 0, 0);
        checkOutput("b2b_udf_clean", stat_udf, 0);
        applyStimulus(1, 2, 0, 0, 0, 0, 0);
        checkOutput("udf_stale", io_in, 7);
        clockEdge();
        applyStimulus(0, 2, 0, 0, 0, 0, 0);
        checkOutput("udf_set", stat_udf, 1);
        applyStimulus(0, 2, 0, 0, 0, 0, 1);
        clockEdge();
        applyStimulus(0, 2, 0, 0, 0, 0, 0);
        checkOutput("udf_clr", stat_udf, 0);
        applyStimulus(1, 2, 0, 0, 0, 0, 1);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("udf_clr_priority", stat_udf, 0);

        // Fill, overflow, and drain the output queue.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 1, 3'(k), 32'(k*10), 0, 0);
            clockEdge();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("fifo4_ovf", stat_ovf, 0);
        applyStimulus(0, 0, 1, 5, 50, 0, 0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("fifo5_ovf", stat_ovf, 1);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            checkOutput($sformatf("drain%0d_valid", k), ext_out_valid, 1);
            checkOutput($sformatf("drain%0d_addr", k), ext_out_addr, 64'(k));
            checkOutput($sformatf("drain%0d_data", k), ext_out_data, 64'(k*10));
            clockEdge();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("drain_empty", ext_out_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("ovf_clr", stat_ovf, 0);

        // Push and pop together on a full queue.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 1, 3'(k), 32'(k*10), 0, 0);
            clockEdge();
        end
        applyStimulus(0, 0, 1, 5, 50, 1, 0);
        checkOutput("swap_head_addr", ext_out_addr, 1);
        checkOutput("swap_head_data", ext_out_data, 10);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("swap_no_ovf", stat_ovf, 0);
        for (int k = 2; k <= 5; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            checkOutput($sformatf("swap%0d_addr", k), ext_out_addr, 64'(k));
            checkOutput($sformatf("swap%0d_data", k), ext_out_data, 64'(k*10));
            clockEdge();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("swap_empty", ext_out_valid, 0);

        // Narrow instance: addresses 6 and 7 fall outside six channels.
        s_ext_in_data[5*32 +: 32] = 32'habcd;
        s_ext_in_valid = 6'h20;
        clockEdge();
        s_ext_in_valid = '0;
        #1;
        checkOutput("s_itr", s_itr, 1);
        checkOutput("s_ch5_full", s_ext_in_ready, 6'h1f);
        s_req = 1; s_addr_in = 6;
        #1;
        checkOutput("s_oor6_io_in", s_io_in, 0);
        checkOutput("s_oor6_ready", s_ext_in_ready, 6'h1f);
        clockEdge();
        checkOutput("s_oor6_udf", s_stat_udf, 0);
        checkOutput("s_oor6_full_kept", s_ext_in_ready, 6'h1f);
        s_addr_in = 7;
        #1;
        checkOutput("s_oor7_io_in", s_io_in, 0);
        clockEdge();
        checkOutput("s_oor7_udf", s_stat_udf, 0);
        s_addr_in = 5;
        #1;
        checkOutput("s_rd5_io_in", s_io_in, 32'habcd);
        checkOutput("s_rd5_ready", s_ext_in_ready, 6'h3f);
        clockEdge();
        s_req = 0;
        #1;
        checkOutput("s_rd5_empty", s_ext_in_ready, 6'h3f);
        s_out_en = 1; s_addr_out = 7; s_data_out = 32'h77;
        clockEdge();
        s_out_en = 0;
        #1;
        checkOutput("s_oor_out_valid", s_ext_out_valid, 1);
        checkOutput("s_oor_out_addr", s_ext_out_addr, 7);
        checkOutput("s_oor_out_data", s_ext_out_data, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
